// File: rtl/piso_serializer_if.sv
// rtl/piso_serializer_if.sv - load handshake and serial output bundle for piso_serializer
interface piso_serializer_if #(
  parameter int WIDTH = 3
);
  logic [WIDTH-1:0] d;
  logic             load_valid;
  logic             load_ready;
  logic             so;
  logic             so_valid;
  logic             busy;
  logic             done;

  modport master (
    output d, load_valid,
    input  load_ready, so, so_valid, busy, done
  );

  modport slave (
    input  d, load_valid,
    output load_ready, so, so_valid, busy, done
  );
endinterface

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out serializer with valid/ready load and framed serial output
// Optional even-parity trailer bit per frame when PISO_PARITY_EN is defined.
module piso_serializer #(
  parameter int WIDTH      = 3,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  piso_serializer_if.slave  bus
);
  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  localparam logic [CW-1:0] LAST_M1 = CW'(WIDTH - 2);
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             so_r, so_n;
  logic             so_valid_r, so_valid_n;
  logic             busy_r, busy_n;
  logic             done_r, done_n;
  logic             accept;
`ifdef PISO_PARITY_EN
  logic             par, par_n;
`endif

  // sreg always holds the not-yet-sent bits aligned so first_bit() yields the next one
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

`ifdef PISO_PARITY_EN
  assign bus.load_ready = (state == IDLE) || (state == PARITY);
`else
  assign bus.load_ready = (state == IDLE) || ((state == SHIFT) && (cnt == LAST));
`endif

  assign accept       = bus.load_valid && bus.load_ready;
  assign bus.so       = so_r;
  assign bus.so_valid = so_valid_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;

  always_comb begin
    state_n    = state;
    sreg_n     = sreg;
    cnt_n      = cnt;
    so_n       = so_r;
    so_valid_n = so_valid_r;
    busy_n     = busy_r;
    done_n     = 1'b0;
`ifdef PISO_PARITY_EN
    par_n      = par;
`endif
    if (accept) begin
      // first bit goes out on the accepting edge, so a new frame abuts the previous one
      state_n    = SHIFT;
      sreg_n     = advance(bus.d);
      cnt_n      = '0;
      so_n       = first_bit(bus.d);
      so_valid_n = 1'b1;
      busy_n     = 1'b1;
`ifdef PISO_PARITY_EN
      par_n      = ^bus.d;
`endif
    end else begin
      case (state)
        SHIFT: begin
          if (cnt != LAST) begin
            so_n   = first_bit(sreg);
            sreg_n = advance(sreg);
            cnt_n  = cnt + 1'b1;
`ifndef PISO_PARITY_EN
            done_n = (cnt == LAST_M1);
`endif
          end else begin
`ifdef PISO_PARITY_EN
            state_n = PARITY;
            so_n    = par;
            cnt_n   = CW'(WIDTH);
            done_n  = 1'b1;
`else
            state_n    = IDLE;
            sreg_n     = '0;
            cnt_n      = '0;
            so_n       = IDLE_LEVEL;
            so_valid_n = 1'b0;
            busy_n     = 1'b0;
`endif
          end
        end
`ifdef PISO_PARITY_EN
        PARITY: begin
          state_n    = IDLE;
          sreg_n     = '0;
          cnt_n      = '0;
          so_n       = IDLE_LEVEL;
          so_valid_n = 1'b0;
          busy_n     = 1'b0;
        end
`endif
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sreg       <= '0;
      cnt        <= '0;
      so_r       <= IDLE_LEVEL;
      so_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
`ifdef PISO_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      sreg       <= sreg_n;
      cnt        <= cnt_n;
      so_r       <= so_n;
      so_valid_r <= so_valid_n;
      busy_r     <= busy_n;
      done_r     <= done_n;
`ifdef PISO_PARITY_EN
      par        <= par_n;
`endif
    end
  end
endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - scoreboard bench for piso_serializer, MSB-first and LSB-first instances
module tb_piso_serializer;
  localparam int W = 3;
`ifdef PISO_PARITY_EN
  localparam bit PAR = 1'b1;
  localparam int FL  = W + 1;
`else
  localparam bit PAR = 1'b0;
  localparam int FL  = W;
`endif

  typedef struct packed {
    logic b;
    logic last;
  } item_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(W)) bus_m ();
  piso_serializer_if #(.WIDTH(W)) bus_l ();

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .bus(bus_m)
  );
  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .bus(bus_l)
  );

  item_t q_m[$];
  item_t q_l[$];
  int    checks   = 0;
  int    errors   = 0;
  int    pending  = 0;
  bit    acc_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic item_t mk(input logic b, input logic last);
    item_t it;
    it.b    = b;
    it.last = last;
    return it;
  endfunction

  // A frame is the word in transmit order, then optionally its even parity; the final item carries DONE.
  task automatic push_frame(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      q_m.push_back(mk(w[W-1-i], (i == W - 1) && !PAR));
      q_l.push_back(mk(w[i],     (i == W - 1) && !PAR));
    end
    if (PAR) begin
      q_m.push_back(mk(^w, 1'b1));
      q_l.push_back(mk(^w, 1'b1));
    end
  endtask

  // pending = frame bits still to appear on so, counting the one shown in the current cycle
  task automatic drive(input logic v, input logic [W-1:0] dv);
    @(posedge clk);
    pending  = (pending > 0 ? pending - 1 : 0) + (acc_prev ? FL : 0);
    acc_prev = 1'b0;
    #1;
    bus_m.load_valid = v;
    bus_m.d          = dv;
    bus_l.load_valid = v;
    bus_l.d          = dv;
    @(negedge clk);
    chk("load_ready_msb", bus_m.load_ready, pending <= 1);
    chk("load_ready_lsb", bus_l.load_ready, pending <= 1);
    if (v && pending <= 1) begin
      acc_prev = 1'b1;
      push_frame(dv);
    end
  endtask

  task automatic mon_one(input string tag, input logic so, input logic sv, input logic bz,
                         input logic dn, input bit have, input item_t it, input logic idle);
    if (have) begin
      chk({tag, "_so"},       so, it.b);
      chk({tag, "_so_valid"}, sv, 1);
      chk({tag, "_busy"},     bz, 1);
      chk({tag, "_done"},     dn, it.last);
    end else begin
      chk({tag, "_idle_so"},       so, idle);
      chk({tag, "_idle_so_valid"}, sv, 0);
      chk({tag, "_idle_busy"},     bz, 0);
      chk({tag, "_idle_done"},     dn, 0);
    end
  endtask

  always begin
    bit    have_m, have_l;
    item_t it_m, it_l;
    @(posedge clk);
    #2;
    have_m = q_m.size() > 0;
    have_l = q_l.size() > 0;
    it_m   = '0;
    it_l   = '0;
    if (have_m) it_m = q_m.pop_front();
    if (have_l) it_l = q_l.pop_front();
    mon_one("msb", bus_m.so, bus_m.so_valid, bus_m.busy, bus_m.done, have_m, it_m, 1'b0);
    mon_one("lsb", bus_l.so, bus_l.so_valid, bus_l.busy, bus_l.done, have_l, it_l, 1'b1);
  end

  initial begin
    bus_m.load_valid = 1'b0;
    bus_m.d          = '0;
    bus_l.load_valid = 1'b0;
    bus_l.d          = '0;

    repeat (3) drive(1'b0, '0);
    chk("reset_so_msb",       bus_m.so, 0);
    chk("reset_so_lsb",       bus_l.so, 1);
    chk("reset_so_valid",     bus_m.so_valid, 0);
    chk("reset_busy",         bus_m.busy, 0);
    chk("reset_done",         bus_m.done, 0);
    #1 rst_n = 1'b1;

    drive(1'b1, 3'b011);
    repeat (FL + 2) drive(1'b0, '0);

    drive(1'b1, 3'b101);
    repeat (FL) drive(1'b1, 3'b010);
    repeat (FL + 2) drive(1'b0, '0);

    drive(1'b1, 3'b110);
    drive(1'b0, '0);
    drive(1'b1, 3'b001);
    drive(1'b1, 3'b100);
    repeat (2 * FL) drive(1'b0, '0);

    drive(1'b1, 3'b111);
    drive(1'b0, '0);
    drive(1'b0, '0);
    #1 rst_n = 1'b0;
    q_m.delete();
    q_l.delete();
    pending  = 0;
    acc_prev = 1'b0;
    #1;
    chk("async_rst_so_msb",   bus_m.so, 0);
    chk("async_rst_so_lsb",   bus_l.so, 1);
    chk("async_rst_so_valid", bus_m.so_valid, 0);
    chk("async_rst_busy",     bus_m.busy, 0);
    chk("async_rst_done",     bus_m.done, 0);
    repeat (2) drive(1'b0, '0);
    #1 rst_n = 1'b1;
    repeat (FL + 2) drive(1'b0, '0);

    drive(1'b1, 3'b001);
    repeat (FL + 2) drive(1'b0, '0);

    repeat (600) drive(logic'($urandom_range(0, 9) < 6), W'($urandom));

    repeat (FL + 3) drive(1'b0, '0);
    chk("drain_msb", q_m.size(), 0);
    chk("drain_lsb", q_l.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in serial-out serializer that sits directly upstream of the 3-bit SIPO deserializer and drives its SI input. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per CLK rising edge. A SO_VALID qualifier and a DONE pulse frame each word. Back-to-back words stream with no idle gap.

Parameters:
WIDTH, 3, data word width in bits (min 2); default matches the downstream 3-bit SIPO
MSB_FIRST, 1, 1 = D[WIDTH-1] shifted out first; 0 = D[0] first
IDLE_LEVEL, 0, value driven on SO when no bit is being sent

Ports:
CLK  input  1  system clock; all state updates on rising edge
RST_N  input  1  asynchronous active-low reset
D  input  WIDTH  parallel word to serialize
LOAD_VALID  input  1  D is valid; transfer occurs when LOAD_VALID and LOAD_READY are both high at a CLK rising edge
LOAD_READY  output  1  serializer can accept a word this cycle
SO  output  1  serial data out, registered; connects to SIPO SI
SO_VALID  output  1  SO carries a frame bit this cycle
BUSY  output  1  high while in SHIFT (or PARITY) state
DONE  output  1  one-cycle pulse coincident with the last bit of a frame

Behaviour:
- Reset (RST_N low, asynchronous, any state): state=IDLE, shift register=0, bit counter=0, SO=IDLE_LEVEL, SO_VALID=0, BUSY=0, DONE=0, LOAD_READY=1 once RST_N deasserts. Reset mid-frame discards the word; no partial completion and no DONE.
- All outputs are registered except LOAD_READY, which is combinational from state/counter.
- FSM states: IDLE, SHIFT, and PARITY (PARITY only with the optional feature).
- IDLE: LOAD_READY=1, SO=IDLE_LEVEL, SO_VALID=0.
  - On accept: capture D, drive the first bit on SO at that same edge, SO_VALID=1, counter=0, go to SHIFT.
  - Latency: first bit is visible in the cycle immediately after the accept edge.
- SHIFT: each edge presents the next bit and increments the counter. A frame occupies exactly WIDTH consecutive cycles of SO_VALID=1.
- Last data bit (counter=WIDTH-1):
  - DONE=1 for that cycle; LOAD_READY=1 that cycle.
  - If a word is accepted at the ending edge: its first bit follows with no gap, SO_VALID stays high and BUSY stays high.
  - Otherwise: return to IDLE with SO=IDLE_LEVEL and SO_VALID=0.
- LOAD_VALID while LOAD_READY=0 is ignored: no capture, in-flight word unaffected. D may change freely while BUSY.
- Bit order is set by MSB_FIRST. The counter width is clog2(WIDTH+1); there is no wrap beyond WIDTH-1.

Optional Feature:
Macro PISO_PARITY_EN.
- Defined:
  - After the WIDTH data bits, the FSM enters PARITY for one cycle and sends the even parity bit (XOR of the captured word) on SO with SO_VALID=1.
  - DONE and LOAD_READY move to the PARITY cycle and are not asserted on the last data bit.
  - Frame length is WIDTH+1.
- Undefined: no PARITY state, no parity logic. Frame length is WIDTH; behaviour as above.

Test Plan:
- Reset then single word (WIDTH=3, MSB_FIRST=1): D=3'b011, LOAD_VALID pulsed 1 cycle -> SO=0,1,1 in the 3 cycles after accept; SO_VALID high exactly 3 cycles; DONE high only on the 3rd; SO=0 and LOAD_READY=1 afterwards. Downstream SIPO shows Q2..Q0=011.
- Back-to-back: LOAD_VALID held high with 3'b101 then 3'b010 -> SO=1,0,1,0,1,0 contiguous; SO_VALID never drops; DONE pulses on cycles 3 and 6.
- Load while busy: in the 2nd bit cycle of 3'b110, present D=3'b001 with LOAD_VALID=1 and LOAD_READY=0 -> ignored; SO=1,1,0 unaltered. A word presented on the 3rd cycle (LOAD_READY=1) is accepted.
- Async reset mid-frame: RST_N low between clock edges during the 2nd bit of 3'b111 -> SO=0, SO_VALID=0, BUSY=0 immediately, without a CLK edge. After release, DONE is never seen for that word.
- LSB-first (MSB_FIRST=0): D=3'b011 -> SO=1,1,0.
- PISO_PARITY_EN defined: D=3'b011 -> SO=0,1,1,0 (4 cycles); DONE and LOAD_READY on the 4th. D=3'b001 -> parity bit 1.
